fc_requant_serializer: RTL and testbench
========================================

# fc_requant_serializer

Downstream companion of the fc layer wrappers. It captures the parallel `NUM_NEURONS`-wide accumulator vector an FC layer emits on its `valid_out`. It rescales each element to `DATA_WIDTH` fixed point with rounding, optional ReLU and saturation, and streams the elements one per cycle into the next layer's serial `valid_in` / `input_data` port. A two-deep vector buffer (active + pending) absorbs a new vector arriving while the previous one is still streaming.

## Interface
- `NUM_NEURONS`, 16, vector length / elements streamed per vector
- `ACC_WIDTH`, 32, width of each signed input accumulator
- `DATA_WIDTH`, 16, width of each signed output element
- `SHIFT_BITS`, 8, right shift applied to rescale accumulator to output format (≥1)
- `RELU_EN`, 1, 1 = clamp negative results to 0 before saturation

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `valid_in`  in  1  `fc_in` vector valid this cycle (single-cycle strobe)
- `fc_in`  in  `ACC_WIDTH` signed × `[NUM_NEURONS]`  accumulator vector
- `in_ready`  out  1  a `valid_in` this cycle will be accepted
- `data_out`  out  `DATA_WIDTH` signed  requantized element
- `valid_out`  out  1  `data_out` valid
- `last_out`  out  1  marks element `NUM_NEURONS-1` of a vector
- `busy`  out  1  active or pending buffer occupied
- `overflow`  out  1  sticky: a vector was dropped

## Operation
- Buffers: `active` vector + index `idx` (`$clog2(NUM_NEURONS)` bits), and `pending` vector + `pend_full` flag. Raw `ACC_WIDTH` values are stored; quantization happens at issue time on one element.
- States: IDLE (no active vector), RUN (issuing `active[idx]` every cycle).
- `finishing` = RUN && `idx == NUM_NEURONS-1`.
- Accept rules for a cycle with `valid_in`:
  - IDLE → load `active`, `idx`=0, go to RUN.
  - RUN, not finishing, `pend_full`=0 → load `pending`.
  - finishing, `pend_full`=0 → load `active` directly, `idx`=0, stay RUN.
  - finishing, `pend_full`=1 → `pending`→`active`, new vector→`pending`. No drop.
  - RUN, not finishing, `pend_full`=1 → vector dropped, `overflow`←1 (cleared only by `rst`).
- Without `valid_in`: when finishing, a full `pending` moves to `active` (`idx`=0), otherwise go to IDLE. When not finishing, `idx++`.
- `in_ready` = !`pend_full` || finishing. Combinational; no dependency on `valid_in`.
- `busy` = RUN || `pend_full`.
- Requant per element x:
  - `r` = (x + 2^(SHIFT_BITS-1)) >>> SHIFT_BITS, computed in `ACC_WIDTH+1` bits so that 0x7FFF_FFFF cannot wrap. This is arithmetic shift with round-half-up.
  - If `RELU_EN` and `r` < 0, then `r` = 0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].

## Timing
- Output register stage, updated every cycle:
  - `valid_out` ← RUN
  - `last_out` ← finishing
  - `data_out` ← requant(`active[idx]`) when RUN, else 0
- Latency: `valid_in` in cycle 0 while IDLE → element 0 on outputs in cycle 2. Elements k appear in cycle 2+k, contiguous; `last_out` is high in cycle `NUM_NEURONS`+1.
- Back-to-back vectors stream with zero bubble cycles.
- Sustained throughput: one vector per `NUM_NEURONS` cycles. An upstream FC with `INPUT_SIZE ≥ NUM_NEURONS` never overflows.
- Reset values: `data_out`=0, `valid_out`=0, `last_out`=0, `busy`=0, `overflow`=0, `in_ready`=1, state IDLE, `idx`=0, `pend_full`=0. Buffer contents are don't-care but cleared.
- `rst` asserted mid-stream: outputs go to reset values immediately (asynchronously), both buffers are discarded, and no partial vector resumes after release.

## Structure
- Shared package `fc_stream_pkg`: state enum (`FS_IDLE`, `FS_RUN`), the function `requant_sat(x, SHIFT_BITS, RELU_EN)` spec'd above, and saturation min/max constants derived from `DATA_WIDTH`.
- One sub-module: `requant_sat`, a combinational single-element rescale/ReLU/saturate. It is instanced once on the `active[idx]` mux output and is reusable by other layer tails.
- Top holds buffers, FSM, index counter and output register.

## Test plan
1. Reset: assert `rst` with random stimulus → all outputs 0, `in_ready`=1; after release with no `valid_in`, outputs stay idle.
2. Single vector `fc_in[i]` = i·256, SHIFT_BITS=8, strobed in cycle 0 → `data_out` = 0,1,…,15 in cycles 2–17, `valid_out` high exactly those cycles, `last_out` only in cycle 17, `busy` low from cycle 17 on.
3. Arithmetic, `fc_in` values with expected outputs:
   - 0x7FFF_FFFF → 32767
   - 383 → 1, and 384 → 2 (rounding boundary)
   - −512 → 0 with RELU_EN=1, −2 with RELU_EN=0
   - 0x8000_0000 with RELU_EN=0 → −32768
4. Back-to-back: second vector (`fc_in[i]` = −i·256, RELU_EN=0) strobed in cycle 5 → its element 0 in cycle 18 with no gap; `overflow` stays 0.
5. Overflow: `valid_in` in cycles 0, 1, 2 (three distinct vectors), `in_ready` low in cycle 2 → third vector dropped, `overflow`=1 from cycle 3, exactly 32 elements out; also check the finishing-cycle strobe with full `pending` drops nothing.
6. Reset mid-stream: `rst` pulsed in cycle 8 of a vector → `valid_out` drops immediately; a new vector strobed after release streams from element 0 with cycle-2 latency.

Source files
------------

// File: rtl/fc_requant_serializer_pkg.sv
// Shared stream definitions for FC layer tails.
// Holds the FSM state type and the single-element requantize helper.
package fc_stream_pkg;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fs_state_t;

  // Largest representable value of a signed dw-bit element.
  function automatic logic signed [63:0] sat_max(input int unsigned dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest representable value of a signed dw-bit element.
  function automatic logic signed [63:0] sat_min(input int unsigned dw);
    return -sat_max(dw) - 64'sd1;
  endfunction

  // Round-half-up arithmetic right shift, optional ReLU, then saturate to dw bits.
  // The 64-bit working width keeps x + half from wrapping at the accumulator maximum.
  function automatic logic signed [63:0] requant_sat(input logic signed [63:0] x,
                                                     input int unsigned      shift,
                                                     input logic             relu,
                                                     input int unsigned      dw);
    logic signed [63:0] r;
    r = (x + (64'sd1 <<< (shift - 1))) >>> shift;
    if (relu && (r < 64'sd0)) r = '0;
    if (r > sat_max(dw)) r = sat_max(dw);
    if (r < sat_min(dw)) r = sat_min(dw);
    return r;
  endfunction

endpackage

// File: rtl/fc_requant_serializer_if.sv
// Vector-in / element-out stream bundle between an FC layer and the next layer.
interface fc_requant_serializer_if #(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 16
);
  logic                                       valid_in;
  logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0]      fc_in;
  logic                                       in_ready;
  logic signed [DATA_WIDTH-1:0]               data_out;
  logic                                       valid_out;
  logic                                       last_out;
  logic                                       busy;
  logic                                       overflow;

  modport master (
    output valid_in, fc_in,
    input  in_ready, data_out, valid_out, last_out, busy, overflow
  );

  modport slave (
    input  valid_in, fc_in,
    output in_ready, data_out, valid_out, last_out, busy, overflow
  );
endinterface

// File: rtl/fc_requant_serializer_requant_sat.sv
// Combinational single-element rescale / ReLU / saturate.
module requant_sat #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SHIFT_BITS = 8,
  parameter int unsigned RELU_EN    = 1
) (
  input  logic signed [ACC_WIDTH-1:0]  x,
  output logic signed [DATA_WIDTH-1:0] y
);
  logic signed [63:0] xw;

  // Sign-extend and requantize one element.
  always_comb begin
    xw = 64'(x);
    y  = DATA_WIDTH'(fc_stream_pkg::requant_sat(xw, SHIFT_BITS, RELU_EN != 0, DATA_WIDTH));
  end
endmodule

// File: rtl/fc_requant_serializer.sv
// Captures parallel FC accumulator vectors into an active/pending pair and
// streams requantized elements one per cycle through a registered output.
module fc_requant_serializer
  import fc_stream_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SHIFT_BITS  = 8,
  parameter int unsigned RELU_EN     = 1
) (
  input logic                   clk,
  input logic                   rst,
  fc_requant_serializer_if.slave bus
);
  localparam int unsigned IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  fs_state_t                             state;
  logic [IW-1:0]                         idx;
  logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0] active;
  logic [NUM_NEURONS-1:0][ACC_WIDTH-1:0] pending;
  logic                                  pend_full;
  logic                                  overflow;
  logic                                  finishing;
  logic signed [ACC_WIDTH-1:0]           sel;
  logic signed [DATA_WIDTH-1:0]          q;

  // Status decode shared by the FSM and the interface outputs.
  always_comb begin
    finishing    = (state == FS_RUN) && (idx == IW'(NUM_NEURONS - 1));
    sel          = active[idx];
    bus.in_ready = !pend_full || finishing;
    bus.busy     = (state == FS_RUN) || pend_full;
    bus.overflow = overflow;
  end

  requant_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT_BITS(SHIFT_BITS),
    .RELU_EN   (RELU_EN)
  ) u_requant (
    .x(sel),
    .y(q)
  );

  // Buffer FSM: accept, promote pending into active at vector end, detect drops.
  // A finishing cycle frees the active slot, so a strobe then is never dropped
  // even with pending full: pending moves up and the new vector takes its place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FS_IDLE;
      idx       <= '0;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      overflow  <= 1'b0;
    end else if (bus.valid_in) begin
      if (state == FS_IDLE) begin
        active <= bus.fc_in;
        idx    <= '0;
        state  <= FS_RUN;
      end else if (finishing) begin
        idx <= '0;
        if (pend_full) begin
          active  <= pending;
          pending <= bus.fc_in;
        end else begin
          active <= bus.fc_in;
        end
      end else begin
        idx <= idx + IW'(1);
        if (!pend_full) begin
          pending   <= bus.fc_in;
          pend_full <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end else if (state == FS_RUN) begin
      if (finishing) begin
        idx <= '0;
        if (pend_full) begin
          active    <= pending;
          pend_full <= 1'b0;
        end else begin
          state <= FS_IDLE;
        end
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.last_out  <= 1'b0;
    end else begin
      bus.valid_out <= (state == FS_RUN);
      bus.last_out  <= finishing;
      bus.data_out  <= (state == FS_RUN) ? q : '0;
    end
  end
endmodule

// File: tb/tb_fc_requant_serializer.sv
// Directed self-checking bench; one DUT with ReLU, one without, same stimulus.
module tb_fc_requant_serializer;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  valid_in = 1'b0;
  logic [15:0][31:0]     fc_in = '0;
  int                    checks = 0;
  int                    failures = 0;

  always #5 clk = ~clk;

  fc_requant_serializer_if #(.NUM_NEURONS(16), .ACC_WIDTH(32), .DATA_WIDTH(16)) bus_relu ();
  fc_requant_serializer_if #(.NUM_NEURONS(16), .ACC_WIDTH(32), .DATA_WIDTH(16)) bus_raw ();

  assign bus_relu.valid_in = valid_in;
  assign bus_relu.fc_in    = fc_in;
  assign bus_raw.valid_in  = valid_in;
  assign bus_raw.fc_in     = fc_in;

  fc_requant_serializer #(.NUM_NEURONS(16), .ACC_WIDTH(32), .DATA_WIDTH(16),
                          .SHIFT_BITS(8), .RELU_EN(1)) dut_relu (
    .clk(clk), .rst(rst), .bus(bus_relu));

  fc_requant_serializer #(.NUM_NEURONS(16), .ACC_WIDTH(32), .DATA_WIDTH(16),
                          .SHIFT_BITS(8), .RELU_EN(0)) dut_raw (
    .clk(clk), .rst(rst), .bus(bus_raw));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in "cycle 0": reset released, inputs idle.
  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    fc_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      valid_in = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) fc_in[i] = $urandom;
      step();
      checks++;
      if (bus_relu.valid_out !== 1'b0 || bus_relu.last_out !== 1'b0 || bus_relu.busy !== 1'b0 ||
          bus_relu.overflow !== 1'b0 || bus_relu.in_ready !== 1'b1 || bus_relu.data_out !== 16'sd0) begin
        failures++;
        $display("FAIL reset_hold c=%0d got v=%0b l=%0b b=%0b o=%0b r=%0b d=%0d exp 0,0,0,0,1,0", c,
                 bus_relu.valid_out, bus_relu.last_out, bus_relu.busy, bus_relu.overflow,
                 bus_relu.in_ready, bus_relu.data_out);
      end
    end
    rst = 1'b0;
    valid_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus_relu.valid_out !== 1'b0 || bus_relu.busy !== 1'b0 || bus_relu.in_ready !== 1'b1 ||
          bus_relu.data_out !== 16'sd0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got v=%0b b=%0b r=%0b d=%0d exp 0,0,1,0", c,
                 bus_relu.valid_out, bus_relu.busy, bus_relu.in_ready, bus_relu.data_out);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 16; i++) fc_in[i] = 32'(i * 256);
    valid_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      valid_in = 1'b0;
      checks++;
      if (bus_relu.valid_out !== (c >= 2 && c <= 17)) begin
        failures++;
        $display("FAIL single_valid c=%0d got=%0b exp=%0b", c, bus_relu.valid_out, (c >= 2 && c <= 17));
      end
      checks++;
      if (bus_relu.last_out !== (c == 17)) begin
        failures++;
        $display("FAIL single_last c=%0d got=%0b exp=%0b", c, bus_relu.last_out, (c == 17));
      end
      checks++;
      if (bus_relu.busy !== (c <= 16)) begin
        failures++;
        $display("FAIL single_busy c=%0d got=%0b exp=%0b", c, bus_relu.busy, (c <= 16));
      end
      if (c >= 2 && c <= 17) begin
        checks++;
        if (bus_relu.data_out !== 16'(c - 2)) begin
          failures++;
          $display("FAIL single_data c=%0d got=%0d exp=%0d", c, bus_relu.data_out, c - 2);
        end
      end
    end
  endtask

  task automatic test_arith();
    logic signed [15:0] exp_relu [5];
    logic signed [15:0] exp_raw [5];
    exp_relu = '{16'sd32767, 16'sd1, 16'sd2, 16'sd0, 16'sd0};
    exp_raw  = '{16'sd32767, 16'sd1, 16'sd2, -16'sd2, -16'sd32768};
    do_reset();
    fc_in = '0;
    fc_in[0] = 32'h7FFF_FFFF;
    fc_in[1] = 32'd383;
    fc_in[2] = 32'd384;
    fc_in[3] = -32'sd512;
    fc_in[4] = 32'h8000_0000;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus_relu.data_out !== exp_relu[k]) begin
        failures++;
        $display("FAIL arith_relu k=%0d got=%0d exp=%0d", k, bus_relu.data_out, exp_relu[k]);
      end
      checks++;
      if (bus_raw.data_out !== exp_raw[k]) begin
        failures++;
        $display("FAIL arith_raw k=%0d got=%0d exp=%0d", k, bus_raw.data_out, exp_raw[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] e;
    do_reset();
    for (int i = 0; i < 16; i++) fc_in[i] = 32'(i * 256);
    valid_in = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      valid_in = 1'b0;
      if (c == 5) begin
        for (int i = 0; i < 16; i++) fc_in[i] = 32'(-i * 256);
        valid_in = 1'b1;
      end
      checks++;
      if (bus_raw.valid_out !== (c >= 2 && c <= 33)) begin
        failures++;
        $display("FAIL b2b_valid c=%0d got=%0b exp=%0b", c, bus_raw.valid_out, (c >= 2 && c <= 33));
      end
      checks++;
      if (bus_raw.last_out !== (c == 17 || c == 33)) begin
        failures++;
        $display("FAIL b2b_last c=%0d got=%0b exp=%0b", c, bus_raw.last_out, (c == 17 || c == 33));
      end
      if (c >= 2 && c <= 33) begin
        e = (c <= 17) ? 16'(c - 2) : 16'(-(c - 18));
        checks++;
        if (bus_raw.data_out !== e) begin
          failures++;
          $display("FAIL b2b_data c=%0d got=%0d exp=%0d", c, bus_raw.data_out, e);
        end
      end
    end
    checks++;
    if (bus_raw.overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_overflow got=%0b exp=0", bus_raw.overflow);
    end
  endtask

  task automatic test_overflow();
    int n;
    int offs;
    // Three strobes in cycles 0,1,2: the third hits a full pending slot.
    do_reset();
    n = 0;
    for (int i = 0; i < 16; i++) fc_in[i] = 32'(i * 256);
    valid_in = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      valid_in = 1'b0;
      if (c == 1) begin
        for (int i = 0; i < 16; i++) fc_in[i] = 32'((i + 100) * 256);
        valid_in = 1'b1;
      end
      if (c == 2) begin
        checks++;
        if (bus_relu.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL ovf_in_ready c=2 got=%0b exp=0", bus_relu.in_ready);
        end
        checks++;
        if (bus_relu.overflow !== 1'b0) begin
          failures++;
          $display("FAIL ovf_early c=2 got=%0b exp=0", bus_relu.overflow);
        end
        for (int i = 0; i < 16; i++) fc_in[i] = 32'((i + 200) * 256);
        valid_in = 1'b1;
      end
      if (c == 3) begin
        checks++;
        if (bus_relu.overflow !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set c=3 got=%0b exp=1", bus_relu.overflow);
        end
      end
      if (bus_relu.valid_out === 1'b1) begin
        offs = (n < 16) ? n : n - 16 + 100;
        checks++;
        if (bus_relu.data_out !== 16'(offs)) begin
          failures++;
          $display("FAIL ovf_data n=%0d got=%0d exp=%0d", n, bus_relu.data_out, offs);
        end
        n++;
      end
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL ovf_count got=%0d exp=32", n);
    end
    checks++;
    if (bus_relu.overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky got=%0b exp=1", bus_relu.overflow);
    end

    // Strobe in the finishing cycle with pending full: nothing is lost.
    do_reset();
    n = 0;
    for (int i = 0; i < 16; i++) fc_in[i] = 32'(i * 256);
    valid_in = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      step();
      valid_in = 1'b0;
      if (c == 1) begin
        for (int i = 0; i < 16; i++) fc_in[i] = 32'((i + 100) * 256);
        valid_in = 1'b1;
      end
      if (c == 16) begin
        checks++;
        if (bus_relu.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL fin_in_ready c=16 got=%0b exp=1", bus_relu.in_ready);
        end
        for (int i = 0; i < 16; i++) fc_in[i] = 32'((i + 200) * 256);
        valid_in = 1'b1;
      end
      if (bus_relu.valid_out === 1'b1) begin
        offs = (n < 16) ? n : (n < 32) ? n - 16 + 100 : n - 32 + 200;
        checks++;
        if (bus_relu.data_out !== 16'(offs) || c != n + 2) begin
          failures++;
          $display("FAIL fin_data n=%0d c=%0d got=%0d exp=%0d at c=%0d", n, c, bus_relu.data_out, offs, n + 2);
        end
        n++;
      end
    end
    checks++;
    if (n != 48) begin
      failures++;
      $display("FAIL fin_count got=%0d exp=48", n);
    end
    checks++;
    if (bus_relu.overflow !== 1'b0) begin
      failures++;
      $display("FAIL fin_overflow got=%0b exp=0", bus_relu.overflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 16; i++) fc_in[i] = 32'(i * 256);
    valid_in = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      valid_in = 1'b0;
    end
    checks++;
    if (bus_relu.valid_out !== 1'b1 || bus_relu.data_out !== 16'sd6) begin
      failures++;
      $display("FAIL mid_pre got v=%0b d=%0d exp v=1 d=6", bus_relu.valid_out, bus_relu.data_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_relu.valid_out !== 1'b0 || bus_relu.busy !== 1'b0 || bus_relu.in_ready !== 1'b1 ||
        bus_relu.data_out !== 16'sd0) begin
      failures++;
      $display("FAIL mid_async got v=%0b b=%0b r=%0b d=%0d exp 0,0,1,0", bus_relu.valid_out,
               bus_relu.busy, bus_relu.in_ready, bus_relu.data_out);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus_relu.valid_out !== 1'b0 || bus_relu.busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_no_resume c=%0d got v=%0b b=%0b exp 0,0", c, bus_relu.valid_out, bus_relu.busy);
      end
    end
    for (int i = 0; i < 16; i++) fc_in[i] = 32'((i + 50) * 256);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    checks++;
    if (bus_relu.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL mid_latency c=1 got=%0b exp=0", bus_relu.valid_out);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus_relu.valid_out !== 1'b1 || bus_relu.data_out !== 16'(50 + k)) begin
        failures++;
        $display("FAIL mid_restart k=%0d got v=%0b d=%0d exp v=1 d=%0d", k, bus_relu.valid_out,
                 bus_relu.data_out, 50 + k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
